// File: rtl/hammerparrot_print_stat_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hammerparrot_print_stat_monitor                               |
// | Purpose  : decodes print_stat snoop tags, times kernels, signals drain   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hammerparrot_print_stat_monitor #(
  parameter int data_width_p   = 32,
  parameter int ctr_width_p    = 64,
  parameter int count_width_p  = 16,
  parameter int drain_cycles_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     print_stat_v_i,
  input  logic [data_width_p-1:0]  print_stat_tag_i,
  input  logic [ctr_width_p-1:0]   global_ctr_i,
  output logic                     active_o,
  output logic                     kernel_cycles_v_o,
  output logic [ctr_width_p-1:0]   kernel_cycles_o,
  output logic [3:0]               kernel_id_o,
  output logic [count_width_p-1:0] stat_count_o,
  output logic                     finish_o,
  output logic                     fail_o,
  output logic                     err_o,
  output logic                     done_o
);

  localparam int c_drain_w = (drain_cycles_p > 1) ? $clog2(drain_cycles_p) : 1;
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(drain_cycles_p - 1);

  localparam logic [1:0] c_op_start  = 2'b00;
  localparam logic [1:0] c_op_end    = 2'b01;
  localparam logic [1:0] c_op_finish = 2'b10;
  localparam logic [1:0] c_op_fail   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                   r_state, w_state_next;
  logic [ctr_width_p-1:0]   r_start_ctr, w_start_ctr_next;
  logic [3:0]               r_start_id, w_start_id_next;
  logic [c_drain_w-1:0]     r_drain_cnt, w_drain_cnt_next;
  logic                     r_kcyc_v, w_kcyc_v_next;
  logic [ctr_width_p-1:0]   r_kcyc, w_kcyc_next;
  logic [3:0]               r_kid, w_kid_next;
  logic [count_width_p-1:0] r_count, w_count_next;
  logic                     r_finish, w_finish_next;
  logic                     r_fail, w_fail_next;
  logic                     r_err, w_err_next;
  logic                     r_done, w_done_next;

  logic [1:0] w_op;
  logic [3:0] w_id;
  logic       w_unused_tag_bits;

  assign w_op = print_stat_tag_i[data_width_p-1 -: 2];
  assign w_id = print_stat_tag_i[3:0];
  assign w_unused_tag_bits = ^print_stat_tag_i[data_width_p-3:4];

  always_comb begin
    w_state_next     = r_state;
    w_start_ctr_next = r_start_ctr;
    w_start_id_next  = r_start_id;
    w_drain_cnt_next = r_drain_cnt;
    w_kcyc_v_next    = 1'b0;
    w_kcyc_next      = r_kcyc;
    w_kid_next       = r_kid;
    w_count_next     = r_count;
    w_finish_next    = r_finish;
    w_fail_next      = r_fail;
    w_err_next       = r_err;
    w_done_next      = r_done;

    // DONE is terminal: tags there are neither decoded nor counted
    if (print_stat_v_i && (r_state != ST_DONE) && (r_count != '1)) begin
      w_count_next = r_count + count_width_p'(1);
    end

    unique case (r_state)
      ST_IDLE: begin
        if (print_stat_v_i) begin
          unique case (w_op)
            c_op_start: begin
              w_state_next     = ST_RUN;
              w_start_ctr_next = global_ctr_i;
              w_start_id_next  = w_id;
            end
            c_op_end:    w_err_next = 1'b1;
            c_op_finish: begin
              w_state_next  = ST_DRAIN;
              w_finish_next = 1'b1;
            end
            default: begin
              w_state_next = ST_DRAIN;
              w_fail_next  = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (print_stat_v_i) begin
          unique case (w_op)
            c_op_start: begin
              w_err_next       = 1'b1;
              w_start_ctr_next = global_ctr_i;
              w_start_id_next  = w_id;
            end
            c_op_end: begin
              if (w_id == r_start_id) begin
                w_state_next  = ST_IDLE;
                // modular subtraction keeps the delta right across counter wrap
                w_kcyc_next   = global_ctr_i - r_start_ctr;
                w_kid_next    = w_id;
                w_kcyc_v_next = 1'b1;
              end else begin
                w_err_next = 1'b1;
              end
            end
            c_op_finish: begin
              w_state_next  = ST_DRAIN;
              w_finish_next = 1'b1;
              w_err_next    = 1'b1;
            end
            default: begin
              w_state_next = ST_DRAIN;
              w_fail_next  = 1'b1;
              w_err_next   = 1'b1;
            end
          endcase
        end
      end
      ST_DRAIN: begin
        if (print_stat_v_i && (w_op == c_op_fail)) begin
          w_fail_next = 1'b1;
        end
        if (r_drain_cnt == c_drain_last) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
        end else begin
          w_drain_cnt_next = r_drain_cnt + c_drain_w'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_start_ctr <= '0;
      r_start_id  <= '0;
      r_drain_cnt <= '0;
      r_kcyc_v    <= 1'b0;
      r_kcyc      <= '0;
      r_kid       <= '0;
      r_count     <= '0;
      r_finish    <= 1'b0;
      r_fail      <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_start_ctr <= w_start_ctr_next;
      r_start_id  <= w_start_id_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_kcyc_v    <= w_kcyc_v_next;
      r_kcyc      <= w_kcyc_next;
      r_kid       <= w_kid_next;
      r_count     <= w_count_next;
      r_finish    <= w_finish_next;
      r_fail      <= w_fail_next;
      r_err       <= w_err_next;
      r_done      <= w_done_next;
    end
  end

  assign active_o          = (r_state == ST_RUN);
  assign kernel_cycles_v_o = r_kcyc_v;
  assign kernel_cycles_o   = r_kcyc;
  assign kernel_id_o       = r_kid;
  assign stat_count_o      = r_count;
  assign finish_o          = r_finish;
  assign fail_o            = r_fail;
  assign err_o             = r_err;
  assign done_o            = r_done;

endmodule
`default_nettype wire
